// File: rtl/sum_fifo_pkg.sv
// Shared constants and types for the adder result FIFO.
// Build option: define SUM_FIFO_FWFT_EN for first-word fall-through reads.
package sum_fifo_pkg;

    localparam int DATA_W_DEF = 5;
    localparam int DEPTH_DEF  = 8;
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF) + 1;

    typedef logic [DATA_W_DEF-1:0] sum_t;

endpackage

// File: rtl/sum_fifo_mem.sv
// Unreset storage array for sum_fifo: one synchronous write port,
// one combinational read port.
module sum_fifo_mem #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sum_fifo.sv
// Result buffer behind the 4-bit adder: pointers, status, sticky errors, read port.
// Define SUM_FIFO_FWFT_EN for first-word fall-through; default is a registered rd_data.
module sum_fifo
    import sum_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;

    // The MSB is a wrap bit, so equal indexes mean empty or full depending on it.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    sum_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SUM_FIFO_FWFT_EN
    assign rd_data = empty ? '0 : head;
`else
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (pop) begin
            rd_data_q <= head;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
